// File: rtl/mux_pkg.sv
// mux_pkg -- shared lane-packer helpers: output width rule and beat-to-lane mapping.
// Rev 1.0
`default_nettype none

package mux_pkg;

  function automatic int unsigned out_width(input int unsigned in_w, input int unsigned ratio);
    return in_w * ratio;
  endfunction

  // First beat of a word lands in the top lane when msb_first is set.
  function automatic int unsigned lane_index(input int unsigned cnt, input bit msb_first,
                                             input int unsigned ratio);
    return msb_first ? (ratio - 1 - cnt) : cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_out_reg.sv
// mux_out_reg -- one-entry valid/ready output register holding the packed word and keep mask.
// Rev 1.0
`default_nettype none

module mux_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic              o_slot_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;

  // A load is only requested when the slot is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_keep      = r_keep;
  assign o_slot_free = ~r_valid | i_ready;

endmodule

`default_nettype wire

// File: rtl/mux_narrow_wide.sv
// mux_narrow_wide -- packs RATIO narrow beats into one wide word with keep mask, flush and valid/ready.
// Rev 1.0
`default_nettype none

module mux_narrow_wide
  import mux_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk_4f,
  input  logic                  reset_L,
  input  logic [IN_W-1:0]       data_in,
  input  logic                  valid_in,
  input  logic                  flush_in,
  output logic                  ready_in,
  output logic [IN_W*RATIO-1:0] data_out,
  output logic [RATIO-1:0]      keep_out,
  output logic                  valid_out,
  input  logic                  ready_out
);

  localparam int OUT_W = out_width(IN_W, RATIO);
  localparam int CW    = $clog2(RATIO);

  logic [CW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_acc;
  logic [RATIO-1:0] r_kacc;

  logic [31:0]      w_lane;
  logic [OUT_W-1:0] w_beat_word;
  logic [OUT_W-1:0] w_acc_merged;
  logic [RATIO-1:0] w_beat_keep;
  logic [RATIO-1:0] w_kacc_merged;
  logic             w_last;
  logic             w_nonempty;
  logic             w_close_req;
  logic             w_slot_free;
  logic             w_ready;
  logic             w_beat_acc;
  logic             w_close;

  assign w_lane      = lane_index(32'(r_cnt), MSB_FIRST != 0, RATIO);
  assign w_beat_word = {{(OUT_W-IN_W){1'b0}}, data_in} << (w_lane * IN_W);
  assign w_beat_keep = {{(RATIO-1){1'b0}}, 1'b1} << w_lane;

  assign w_last      = (r_cnt == CW'(RATIO-1));
  assign w_nonempty  = (r_cnt != '0);
  // Close request is independent of data_in so ready_in never depends on it.
  assign w_close_req = (valid_in & w_last) | (flush_in & (valid_in | w_nonempty));
  assign w_ready     = reset_L & (w_slot_free | ~w_close_req);
  assign w_beat_acc  = valid_in & w_ready;
  assign w_close     = w_close_req & w_ready;

  assign w_acc_merged  = r_acc  | (w_beat_acc ? w_beat_word : '0);
  assign w_kacc_merged = r_kacc | (w_beat_acc ? w_beat_keep : '0);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_kacc <= '0;
    end else if (w_close) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_kacc <= '0;
    end else if (w_beat_acc) begin
      r_cnt  <= r_cnt + CW'(1);
      r_acc  <= w_acc_merged;
      r_kacc <= w_kacc_merged;
    end
  end

  mux_out_reg #(
    .DATA_W (OUT_W),
    .KEEP_W (RATIO)
  ) u_out_reg (
    .clk         (clk_4f),
    .rst_n       (reset_L),
    .i_load      (w_close),
    .i_data      (w_acc_merged),
    .i_keep      (w_kacc_merged),
    .i_ready     (ready_out),
    .o_valid     (valid_out),
    .o_data      (data_out),
    .o_keep      (keep_out),
    .o_slot_free (w_slot_free)
  );

  assign ready_in = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_mux_narrow_wide.sv
// tb_mux_narrow_wide -- three packer configurations on shared stimulus, each checked against a word-level model.
// Rev 1.0
`default_nettype none

module tb_mux_narrow_wide;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       flush_in;
  logic       ready_out;

  always #5 clk_4f = ~clk_4f;

  logic        rin0, rin1, rin2, vout0, vout1, vout2;
  logic [31:0] dout0, dout1, dout2;
  logic [3:0]  kout0, kout1;
  logic [7:0]  kout2;

  mux_narrow_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_dut0 (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .flush_in(flush_in), .ready_in(rin0), .data_out(dout0), .keep_out(kout0),
    .valid_out(vout0), .ready_out(ready_out));

  mux_narrow_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_dut1 (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .flush_in(flush_in), .ready_in(rin1), .data_out(dout1), .keep_out(kout1),
    .valid_out(vout1), .ready_out(ready_out));

  mux_narrow_wide #(.IN_W(4), .RATIO(8), .MSB_FIRST(1)) u_dut2 (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in[3:0]), .valid_in(valid_in),
    .flush_in(flush_in), .ready_in(rin2), .data_out(dout2), .keep_out(kout2),
    .valid_out(vout2), .ready_out(ready_out));

  logic [31:0] g_d [3];
  logic [7:0]  g_k [3];
  logic        g_v [3];
  logic        g_r [3];

  assign g_d[0] = dout0;          assign g_d[1] = dout1;          assign g_d[2] = dout2;
  assign g_k[0] = {4'b0, kout0};  assign g_k[1] = {4'b0, kout1};  assign g_k[2] = kout2;
  assign g_v[0] = vout0;          assign g_v[1] = vout1;          assign g_v[2] = vout2;
  assign g_r[0] = rin0;           assign g_r[1] = rin1;           assign g_r[2] = rin2;

  int p_w [3] = '{8, 8, 4};
  int p_r [3] = '{4, 4, 8};
  int p_m [3] = '{1, 0, 1};

  // Reference: list of beats in the open word plus a one-word output slot.
  logic [7:0]  m_beats [3][8];
  int          m_n [3];
  bit          m_v [3];
  logic [31:0] m_d [3];
  logic [7:0]  m_k [3];
  int          n_acc [3];
  int          n_out [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_closing(input int k);
    return (valid_in && (m_n[k] == p_r[k] - 1)) || (flush_in && (valid_in || m_n[k] > 0));
  endfunction

  function automatic bit m_ready(input int k);
    return reset_L && !(m_v[k] && !ready_out && m_closing(k));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_v[k] = 0; m_d[k] = '0; m_k[k] = '0;
      n_acc[k] = 0; n_out[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit cl, rd;
      logic [7:0] msk;
      cl  = m_closing(k);
      rd  = m_ready(k);
      msk = (p_w[k] == 8) ? 8'hFF : 8'h0F;
      if (m_v[k] && ready_out) m_v[k] = 0;
      if (rd && valid_in) begin
        m_beats[k][m_n[k]] = data_in & msk;
        m_n[k]++;
        n_acc[k]++;
      end
      if (rd && cl) begin
        logic [31:0] w;
        logic [7:0]  kp;
        w = '0; kp = '0;
        for (int i = 0; i < m_n[k]; i++) begin
          int ln;
          ln = (p_m[k] != 0) ? (p_r[k] - 1 - i) : i;
          w  = w | (32'(m_beats[k][i]) << (ln * p_w[k]));
          kp = kp | (8'(1) << ln);
        end
        m_d[k] = w; m_k[k] = kp; m_v[k] = 1; m_n[k] = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d.ready_in", k), 32'(g_r[k]), 32'(m_ready(k)));
      if (g_v[k] && ready_out) n_out[k] += $countones(g_k[k]);
    end
    @(posedge clk_4f);
    model_edge();
    @(negedge clk_4f);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d.valid_out", k), 32'(g_v[k]), 32'(m_v[k]));
      if (m_v[k]) begin
        check($sformatf("d%0d.data_out", k), g_d[k], m_d[k]);
        check($sformatf("d%0d.keep_out", k), 32'(g_k[k]), 32'(m_k[k]));
      end
    end
  endtask

  task automatic beat(input logic v, input logic f, input logic [7:0] d, input logic ro);
    valid_in = v; flush_in = f; data_in = d; ready_out = ro;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.d%0d.ready_in", tag, k), 32'(g_r[k]), 32'd0);
      check($sformatf("%s.d%0d.valid_out", tag, k), 32'(g_v[k]), 32'd0);
      check($sformatf("%s.d%0d.data_out", tag, k), g_d[k], 32'd0);
      check($sformatf("%s.d%0d.keep_out", tag, k), 32'(g_k[k]), 32'd0);
    end
  endtask

  initial begin
    reset_L = 1'b0; valid_in = 1'b0; flush_in = 1'b0; data_in = '0; ready_out = 1'b0;
    model_reset();
    @(negedge clk_4f);
    #1 check_all_zero("reset");
    @(negedge clk_4f);
    reset_L = 1'b1;

    // Full word, both lane orders.
    beat(1, 0, 8'hAA, 1); beat(1, 0, 8'hBB, 1); beat(1, 0, 8'hCC, 1);
    check("full.early_valid", 32'(vout0), 32'd0);
    beat(1, 0, 8'hDD, 1);
    check("full.msb_data", dout0, 32'hAABBCCDD);
    check("full.msb_keep", 32'(kout0), 32'hF);
    check("full.msb_valid", 32'(vout0), 32'd1);
    check("full.lsb_data", dout1, 32'hDDCCBBAA);
    beat(0, 0, 8'h00, 1);
    check("full.one_cycle", 32'(vout0), 32'd0);

    // Partial word via flush, then empty flush.
    beat(1, 0, 8'h11, 1); beat(1, 0, 8'h22, 1); beat(0, 1, 8'h00, 1);
    check("flush.msb_data", dout0, 32'h11220000);
    check("flush.msb_keep", 32'(kout0), 32'hC);
    check("flush.lsb_data", dout1, 32'h00002211);
    check("flush.lsb_keep", 32'(kout1), 32'h3);
    beat(0, 1, 8'h00, 1);
    check("flush.empty_noop", 32'(vout0), 32'd0);
    beat(0, 0, 8'h00, 1);

    // Backpressure: second word's closing beat is held off until ready_out returns.
    for (int i = 1; i <= 7; i++) begin
      beat(1, 0, 8'(i), 0);
      if (i < 7) check("stall.ready_early", 32'(rin0), 32'd1);
    end
    check("stall.word1_data", dout0, 32'h01020304);
    valid_in = 1'b1; data_in = 8'h08; ready_out = 1'b0;
    #1 check("stall.ready_drop", 32'(rin0), 32'd0);
    tick();
    tick();
    check("stall.hold_data", dout0, 32'h01020304);
    check("stall.hold_valid", 32'(vout0), 32'd1);
    beat(1, 0, 8'h08, 1);
    check("stall.word2_data", dout0, 32'h05060708);
    check("stall.word2_valid", 32'(vout0), 32'd1);
    beat(0, 0, 8'h00, 1);
    check("stall.drained", 32'(vout0), 32'd0);

    // Asynchronous reset mid-word.
    beat(1, 0, 8'h31, 1); beat(1, 0, 8'h32, 1); beat(1, 0, 8'h33, 1);
    valid_in = 1'b0;
    #2 reset_L = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(posedge clk_4f);
    @(negedge clk_4f);
    reset_L = 1'b1;
    beat(1, 0, 8'h41, 1); beat(1, 0, 8'h42, 1); beat(1, 0, 8'h43, 1); beat(1, 0, 8'h44, 1);
    check("postreset.data", dout0, 32'h41424344);
    check("postreset.keep", 32'(kout0), 32'hF);

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      beat($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
           8'($urandom), $urandom_range(0, 99) < 60);
    end

    // Drain whatever is still open, then every accepted beat must have left.
    beat(0, 1, 8'h00, 1);
    beat(0, 0, 8'h00, 1);
    beat(0, 0, 8'h00, 1);
    for (int k = 0; k < 3; k++)
      check($sformatf("d%0d.beats_out", k), 32'(n_out[k]), 32'(n_acc[k]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_narrow_wide.md
# mux_narrow_wide

Parametrised narrow-to-wide lane packer, the single-clock successor of the fixed 8-to-32 mux. It collects RATIO beats of IN_W bits into one IN_W*RATIO-bit word and adds valid/ready flow control on both sides. It also supports a flush that emits a partially filled word with a lane-keep mask. It sits at the transmit side of the lane datapath, feeding the wide-word stage.

## Interface
- IN_W, 8: width of one input beat in bits.
- RATIO, 4: beats per output word, ≥2. OUT_W = IN_W*RATIO.
- MSB_FIRST, 1: 1 places the first beat in the top lane; 0 places it in the bottom lane.
- clk_4f  in  1  beat-rate clock. One clock; all logic on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  IN_W  input beat.
- valid_in  in  1  data_in is valid.
- flush_in  in  1  close the current word after this cycle's beat, if any. Only sampled when ready_in=1.
- ready_in  out  1  block accepts a beat/flush this cycle.
- data_out  out  OUT_W  packed word.
- keep_out  out  RATIO  one bit per lane; 1 = lane holds a real beat. Bit i corresponds to data_out[i*IN_W +: IN_W].
- valid_out  out  1  data_out/keep_out valid.
- ready_out  in  1  downstream accepts the word.

## Operation
- State: accumulator acc[OUT_W], lane mask kacc[RATIO], fill count cnt (0..RATIO-1), and an output register holding data_out, keep_out and valid_out.
- Beat accept: valid_in & ready_in. The beat is written into lane L:
  - MSB_FIRST=1: L = RATIO-1-cnt.
  - MSB_FIRST=0: L = cnt.
  - kacc[L] is set to 1 and cnt increments.
- Word close happens on an accepted beat when cnt==RATIO-1, or on an accepted flush_in when the word would be non-empty.
  - The completed acc/kacc are copied to the output register, with the current beat merged in.
  - valid_out is set; acc, kacc and cnt clear.
  - Lanes without a beat are driven zero.
- Flush with cnt==0 and no beat is a no-op: no word is emitted and no state changes.
- Output hold: while valid_out=1 and ready_out=0, data_out and keep_out are stable.
- A word transfers when valid_out & ready_out are both 1. valid_out clears unless a new word closes in the same cycle; in that case the new word loads and valid_out stays 1.
- ready_in = reset_L & !(valid_out & !ready_out & closing).
  - "closing" means an accepted beat or flush would close a word this cycle.
  - Non-closing beats are accepted even while the output is stalled, so accumulation continues under backpressure.
- ready_in is combinational from state, ready_out, valid_in and flush_in. There is no combinational path from data_in.

## Timing
- Reset (reset_L=0, asynchronous) sets data_out=0, keep_out=0, valid_out=0, cnt=0, acc=0 and kacc=0. ready_in=0 while reset_L=0.
- After reset deassertion, the first clk_4f edge can accept a beat.
- Latency: the closing beat is accepted at edge N; valid_out=1 with that word after edge N (one cycle).
- Throughput: one beat per cycle with ready_out=1; one full word every RATIO cycles.
- Stall: the output stalls and the next beat would close a word. ready_in drops and the beat is held off. It is accepted in the cycle ready_out returns high; the output is handed off and reloaded in that same cycle.
- Reset mid-word discards the partial accumulation and any pending output word. No flush is emitted.
- If flush_in=1 and valid_in=1 on the last lane (cnt==RATIO-1), exactly one full word is emitted with keep_out all ones. It is never followed by an empty word.

## Structure
- Shared package (mux_pkg): function for lane index from (cnt, MSB_FIRST, RATIO), and the localparam rule OUT_W = IN_W*RATIO.
- Sub-module: mux_out_reg, a one-entry output register with valid/ready, holding data_out/keep_out and exposing "slot free next cycle". The top level holds the accumulator, the counter and the ready_in logic.
- The existing banco/probador arrangement carries over: behavioural and synthesized instances share one probador and are compared cycle by cycle.

## Test plan
- Reset, then 8'hAA,8'hBB,8'hCC,8'hDD on consecutive cycles with ready_out=1 (IN_W=8, RATIO=4, MSB_FIRST=1) -> data_out=32'hAABBCCDD, keep_out=4'b1111, valid_out=1 for one cycle, one edge after 8'hDD.
- Same beats with MSB_FIRST=0 -> data_out=32'hDDCCBBAA.
- Beats 8'h11,8'h22, then flush_in alone -> data_out=32'h11220000, keep_out=4'b1100. Next, flush_in with cnt==0 -> no valid_out.
- ready_out=0 while 8 beats arrive -> first word held stable, ready_in=0 on the 8th beat only. Raise ready_out -> word 1 then word 2 on consecutive cycles, no beat lost.
- Assert reset_L=0 after 3 beats -> all outputs 0 immediately. After release, 4 beats yield only the new word.
- Random valid_in/ready_out/flush_in for 10k cycles with IN_W=4, RATIO=8 -> the scoreboard sees every beat exactly once in order, and the behavioural and synthesized outputs are identical every cycle.
